// File: rtl/time_set_ctrl_pkg.sv
// Shared state encoding, field widths and limits for the time-of-day keeper.
// Used by time_set_ctrl, its interface and the blink mask decode.
package time_set_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } state_e;

  localparam int HH_W = 5;
  localparam int MS_W = 6;

  localparam logic [HH_W-1:0] HH_MAX = 5'd23;
  localparam logic [MS_W-1:0] MS_MAX = 6'd59;

  // Blank bit ordering is {hh, mm, ss}; only the field being edited may blink.
  function automatic logic [2:0] field_mask(input state_e st, input logic phase);
    case (st)
      SET_HH:  field_mask = {phase, 2'b00};
      SET_MM:  field_mask = {1'b0, phase, 1'b0};
      SET_SS:  field_mask = {2'b00, phase};
      default: field_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Key/tick inputs and time/field/blank outputs of time_set_ctrl.
// master = the side producing keys and tick, slave = the time keeper.
interface time_set_ctrl_if;
  import time_set_pkg::*;

  logic              tick;
  logic              key_mode_n;
  logic              key_inc_n;
  logic              key_dec_n;
  logic [HH_W-1:0]   hh;
  logic [MS_W-1:0]   mm;
  logic [MS_W-1:0]   ss;
  logic [1:0]        field;
  logic [2:0]        blank_mask;

  modport master (
    output tick, key_mode_n, key_inc_n, key_dec_n,
    input  hh, mm, ss, field, blank_mask
  );

  modport slave (
    input  tick, key_mode_n, key_inc_n, key_dec_n,
    output hh, mm, ss, field, blank_mask
  );

endinterface

// File: rtl/time_set_ctrl_key_press_det.sv
// Single-key falling-edge detector: one-cycle press pulse per physical press.
// prev resets high so a key held through reset release counts as one press.
module key_press_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  logic r_prev;

  // Previous sampled key level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_key_n;
    end
  end

  assign o_press = r_prev & ~i_key_n;

endmodule

// File: rtl/time_set_ctrl.sv
// Keypad-driven HH:MM:SS keeper/editor feeding the 7-segment display path.
// Optional field blinking while editing is built when TIME_SET_BLINK_EN is defined.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  time_set_ctrl_if.slave  bus
);

  logic w_mode;
  logic w_inc;
  logic w_dec;
  logic w_inc_ok;
  logic w_dec_ok;

  state_e          r_state;
  logic [HH_W-1:0] r_hh;
  logic [MS_W-1:0] r_mm;
  logic [MS_W-1:0] r_ss;

  key_press_det u_mode (.clk(clk), .rst_n(rst_n), .i_key_n(bus.key_mode_n), .o_press(w_mode));
  key_press_det u_inc  (.clk(clk), .rst_n(rst_n), .i_key_n(bus.key_inc_n),  .o_press(w_inc));
  key_press_det u_dec  (.clk(clk), .rst_n(rst_n), .i_key_n(bus.key_dec_n),  .o_press(w_dec));

  // Mode wins over edits; inc together with dec cancels out
  always_comb begin
    w_inc_ok = w_inc & ~w_dec & ~w_mode;
    w_dec_ok = w_dec & ~w_inc & ~w_mode;
  end

  // Time-of-day counter and edit FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_hh    <= 5'd0;
      r_mm    <= 6'd0;
      r_ss    <= 6'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.tick) begin
            if (r_ss == MS_MAX) begin
              r_ss <= 6'd0;
              if (r_mm == MS_MAX) begin
                r_mm <= 6'd0;
                r_hh <= (r_hh == HH_MAX) ? 5'd0 : r_hh + 5'd1;
              end else begin
                r_mm <= r_mm + 6'd1;
              end
            end else begin
              r_ss <= r_ss + 6'd1;
            end
          end
          if (w_mode) begin
            r_state <= SET_HH;
          end
        end
        SET_HH: begin
          if (w_mode) begin
            r_state <= SET_MM;
          end else if (w_inc_ok) begin
            r_hh <= (r_hh == HH_MAX) ? 5'd0 : r_hh + 5'd1;
          end else if (w_dec_ok) begin
            r_hh <= (r_hh == 5'd0) ? HH_MAX : r_hh - 5'd1;
          end
        end
        SET_MM: begin
          if (w_mode) begin
            r_state <= SET_SS;
          end else if (w_inc_ok) begin
            r_mm <= (r_mm == MS_MAX) ? 6'd0 : r_mm + 6'd1;
          end else if (w_dec_ok) begin
            r_mm <= (r_mm == 6'd0) ? MS_MAX : r_mm - 6'd1;
          end
        end
        SET_SS: begin
          if (w_mode) begin
            r_state <= RUN;
          end else if (w_inc_ok) begin
            r_ss <= (r_ss == MS_MAX) ? 6'd0 : r_ss + 6'd1;
          end else if (w_dec_ok) begin
            r_ss <= (r_ss == 6'd0) ? MS_MAX : r_ss - 6'd1;
          end
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign bus.hh    = r_hh;
  assign bus.mm    = r_mm;
  assign bus.ss    = r_ss;
  assign bus.field = r_state;

`ifdef TIME_SET_BLINK_EN
  localparam int unsigned CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic [2:0]       r_blank;
  logic             w_restart;

  // Any state change or applied edit restarts the half-period with the field visible
  always_comb begin
    w_restart = w_mode | ((r_state != RUN) & (w_inc_ok | w_dec_ok));
  end

  // Blink counter, phase and registered blank mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_blank <= 3'b000;
    end else if (w_restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_blank <= 3'b000;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
      r_blank <= field_mask(r_state, ~r_phase);
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_blank <= field_mask(r_state, r_phase);
    end
  end

  assign bus.blank_mask = r_blank;
`else
  assign bus.blank_mask = 3'b000;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus random keys/ticks
// against a seconds-of-day reference model. Blink checks follow TIME_SET_BLINK_EN.
module tb_time_set_ctrl;

  localparam int BD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  time_set_ctrl_if bus ();

  time_set_ctrl #(.BLINK_DIV(BD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: time as seconds since midnight, field 0..3, blink counter/phase
  int m_t;
  int m_field;
  int m_cnt;
  int m_phase;
  bit m_pm, m_pi, m_pd;

  function automatic void model_reset();
    m_t = 0; m_field = 0; m_cnt = 0; m_phase = 0;
    m_pm = 1'b1; m_pi = 1'b1; m_pd = 1'b1;
  endfunction

  function automatic void model_edge(input bit t, input bit mn, input bit in_, input bit dn);
    bit pm, pi, pd, chg;
    int h, m, s, d;
    pm = m_pm & !mn; pi = m_pi & !in_; pd = m_pd & !dn;
    m_pm = mn; m_pi = in_; m_pd = dn;
    chg = 1'b0;
    if (m_field == 0 && t) m_t = (m_t + 1) % 86400;
    if (pm) begin
      m_field = (m_field + 1) % 4;
      chg = 1'b1;
    end else if (m_field != 0 && (pi ^ pd)) begin
      h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
      d = pi ? 1 : -1;
      if (m_field == 1) h = (h + d + 24) % 24;
      else if (m_field == 2) m = (m + d + 60) % 60;
      else s = (s + d + 60) % 60;
      m_t = h * 3600 + m * 60 + s;
      chg = 1'b1;
    end
    if (chg) begin
      m_cnt = 0; m_phase = 0;
    end else if (m_cnt == BD - 1) begin
      m_cnt = 0; m_phase = 1 - m_phase;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endfunction

  function automatic logic [2:0] exp_mask();
`ifdef TIME_SET_BLINK_EN
    logic [2:0] top;
    top = 3'b100;
    if (m_field == 0 || m_phase == 0) return 3'b000;
    return top >> (m_field - 1);
`else
    return 3'b000;
`endif
  endfunction

  function automatic logic [21:0] exp_vec();
    return {5'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60), 2'(m_field), exp_mask()};
  endfunction

  function automatic logic [21:0] got();
    return {bus.hh, bus.mm, bus.ss, bus.field, bus.blank_mask};
  endfunction

  function automatic int cur_val();
    if (m_field == 1) return m_t / 3600;
    if (m_field == 2) return (m_t / 60) % 60;
    return m_t % 60;
  endfunction

  task automatic cyc(input bit t, input bit mn, input bit in_, input bit dn);
    bus.tick = t; bus.key_mode_n = mn; bus.key_inc_n = in_; bus.key_dec_n = dn;
    @(posedge clk);
    if (rst_n) model_edge(t, mn, in_, dn);
    #1;
  endtask

  // k: 0 = mode, 1 = inc, 2 = dec; one low cycle then one released cycle
  task automatic press(input int k);
    cyc(1'b0, k != 0, k != 1, k != 2);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic set_to(input int target);
    for (int i = 0; i < 60 && cur_val() != target; i++) press(1);
  endtask

  task automatic test_reset();
    bus.tick = 1'b0; bus.key_mode_n = 1'b1; bus.key_inc_n = 1'b1; bus.key_dec_n = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (got() !== 22'd0) begin errors++; $display("FAIL reset_state: got %h exp %h", got(), 22'd0); end
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (got() !== exp_vec()) begin errors++; $display("FAIL reset_idle: got %h exp %h", got(), exp_vec()); end
  endtask

  task automatic test_mode_wrap();
    press(0);
    checks++;
    if (bus.field !== 2'd1) begin errors++; $display("FAIL mode_to_hh: got %0d exp 1", bus.field); end
    set_to(23);
    press(1);
    checks++;
    if (bus.hh !== 5'd0 || got() !== exp_vec()) begin errors++; $display("FAIL hh_inc_wrap: got %h exp %h", got(), exp_vec()); end
    press(0);
    checks++;
    if (bus.field !== 2'd2) begin errors++; $display("FAIL mode_to_mm: got %0d exp 2", bus.field); end
    set_to(0);
    press(2);
    checks++;
    if (bus.mm !== 6'd59 || got() !== exp_vec()) begin errors++; $display("FAIL mm_dec_wrap: got %h exp %h", got(), exp_vec()); end
    press(0);
    checks++;
    if (bus.field !== 2'd3) begin errors++; $display("FAIL mode_to_ss: got %0d exp 3", bus.field); end
    press(0);
    checks++;
    if (bus.field !== 2'd0 || got() !== exp_vec()) begin errors++; $display("FAIL mode_to_run: got %h exp %h", got(), exp_vec()); end
  endtask

  task automatic test_rollover();
    press(0); set_to(23);
    press(0); set_to(59);
    press(0); set_to(58);
    press(0);
    checks++;
    if (got() !== {5'd23, 6'd59, 6'd58, 2'd0, 3'b000}) begin errors++; $display("FAIL preset_235958: got %h", got()); end
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (got() !== {5'd23, 6'd59, 6'd59, 2'd0, 3'b000}) begin errors++; $display("FAIL tick_235959: got %h", got()); end
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (got() !== 22'd0 || got() !== exp_vec()) begin errors++; $display("FAIL tick_midnight: got %h exp %h", got(), exp_vec()); end
  endtask

  task automatic test_frozen();
    press(0); press(0); press(0);
    set_to(10);
    repeat (5) cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.ss !== 6'd10 || bus.field !== 2'd3 || got() !== exp_vec()) begin errors++; $display("FAIL frozen_ss10: got %h exp %h", got(), exp_vec()); end
    press(0);
  endtask

  task automatic test_hold();
    press(0); set_to(4);
    repeat (1000) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.hh !== 5'd5 || got() !== exp_vec()) begin errors++; $display("FAIL hold_once: got hh %0d exp 5", bus.hh); end
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.field !== 2'd2 || bus.hh !== 5'd5) begin errors++; $display("FAIL mode_beats_inc: got field %0d hh %0d exp 2 5", bus.field, bus.hh); end
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    press(0); press(0);
  endtask

  task automatic test_simul();
    int t0;
    t0 = m_t;
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.field !== 2'd1 || got() !== exp_vec() || m_t != (t0 + 1) % 86400) begin errors++; $display("FAIL tick_mode_run: got %h exp %h", got(), exp_vec()); end
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    press(0); press(0);
    t0 = m_t;
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.field !== 2'd0 || got() !== exp_vec() || m_t != t0) begin errors++; $display("FAIL tick_mode_ss: got %h exp %h", got(), exp_vec()); end
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_blink();
    press(0); press(0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (got() !== exp_vec()) begin errors++; $display("FAIL blink_cycle%0d: got %h exp %h", i, got(), exp_vec()); end
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.blank_mask !== 3'b000 || got() !== exp_vec()) begin errors++; $display("FAIL blink_inc_restart: got %h exp %h", got(), exp_vec()); end
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    press(0); press(0);
  endtask

  task automatic test_random();
    bit t, mn, in_, dn;
    for (int i = 0; i < 3000; i++) begin
      t   = ($urandom_range(0, 3) == 0);
      mn  = ($urandom_range(0, 5) != 0);
      in_ = ($urandom_range(0, 2) != 0);
      dn  = ($urandom_range(0, 2) != 0);
      cyc(t, mn, in_, dn);
      checks++;
      if (got() !== exp_vec()) begin errors++; $display("FAIL random_cycle%0d: got %h exp %h", i, got(), exp_vec()); end
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_edit();
    while (m_field != 0) press(0);
    press(0); set_to(5);
    press(0); set_to(6);
    press(0); set_to(7);
    press(0); press(0); press(0);
    checks++;
    if (got() !== {5'd5, 6'd6, 6'd7, 2'd2, exp_mask()}) begin errors++; $display("FAIL preset_050607: got %h", got()); end
    bus.key_mode_n = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    checks++;
    if (got() !== 22'd0) begin errors++; $display("FAIL reset_mid_edit: got %h exp %h", got(), 22'd0); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.field !== 2'd1 || got() !== exp_vec()) begin errors++; $display("FAIL held_key_after_reset: got %h exp %h", got(), exp_vec()); end
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.field !== 2'd1) begin errors++; $display("FAIL held_key_no_repeat: got %0d exp 1", bus.field); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mode_wrap();
    test_rollover();
    test_frozen();
    test_hold();
    test_simul();
    test_blink();
    test_random();
    test_reset_mid_edit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
